conv_window_buffer: RTL

Streaming 3x3 window generator that sits directly downstream of the pixel normalizer. It consumes one Q8.8 normalized pixel per valid cycle in raster order and holds the two previous image rows in line buffers. It emits a full 3x3 neighbourhood for every interior (valid-mode) output position, feeding the convolution MAC array. There is no backpressure: the block accepts every valid input, matching the normalizer's output protocol.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/conv_window_buffer_if.sv | 20 ++
 rtl/line_buffer.sv | 23 ++
 rtl/conv_window_buffer.sv | 108 ++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared pixel, window and state types for the CNN front end
package cnn_pkg;

   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int KERNEL = 3;

   typedef logic [15:0] pixel_t;
   typedef pixel_t window_t [KERNEL*KERNEL];

   typedef enum logic {
      FILL,
      STREAM
   } state_t;

endpackage

// File: rtl/conv_window_buffer_if.sv
// rtl/conv_window_buffer_if.sv - pixel stream in, 3x3 window stream out
interface conv_window_buffer_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0]   pixel_in;
   logic                valid_in;
   logic [9*DATA_W-1:0] window_out;
   logic                valid_out;
   logic                frame_done;

   modport master (
      output pixel_in, valid_in,
      input  window_out, valid_out, frame_done
   );

   modport slave (
      input  pixel_in, valid_in,
      output window_out, valid_out, frame_done
   );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port circular row buffer, read-before-write
module line_buffer #(
   parameter int DEPTH = 28,
   parameter int WIDTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Asynchronous read returns the old entry in the same cycle it is overwritten.
   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end
endmodule

// File: rtl/conv_window_buffer.sv
// rtl/conv_window_buffer.sv - streaming 3x3 valid-mode window generator
module conv_window_buffer
   import cnn_pkg::*;
#(
   parameter int IMG_W  = cnn_pkg::IMG_W,
   parameter int IMG_H  = cnn_pkg::IMG_H,
   parameter int DATA_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   conv_window_buffer_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   state_t            state;
   logic [DATA_W-1:0] win [KERNEL][KERNEL];
   logic [DATA_W-1:0] lb0_rd;
   logic [DATA_W-1:0] lb1_rd;
   logic              valid_q;
   logic              frame_done_q;
   logic [9*DATA_W-1:0] win_flat;

   logic accept;
   logic col_last;
   logic row_last;

   assign accept   = bus.valid_in;
   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);

   // lb1 holds the previous row, lb0 the row before; lb1 ages into lb0.
   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (lb1_rd),
      .rdata (lb0_rd)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (bus.pixel_in),
      .rdata (lb1_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col          <= '0;
         row          <= '0;
         state        <= FILL;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
               win[r][c] <= '0;
            end
         end
      end else begin
         // In STREAM row is already >= 2, so only the column needs checking.
         valid_q      <= accept && (state == STREAM) && (col >= CW'(2));
         frame_done_q <= accept && col_last && row_last;

         if (accept) begin
            for (int r = 0; r < KERNEL; r++) begin
               for (int c = 0; c < KERNEL - 1; c++) begin
                  win[r][c] <= win[r][c+1];
               end
            end
            win[0][KERNEL-1] <= lb0_rd;
            win[1][KERNEL-1] <= lb1_rd;
            win[2][KERNEL-1] <= bus.pixel_in;

            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end

            case (state)
               FILL:    if (col_last && row == RW'(1)) state <= STREAM;
               STREAM:  if (col_last && row_last)      state <= FILL;
               default: state <= FILL;
            endcase
         end
      end
   end

   always_comb begin
      win_flat = '0;
      for (int r = 0; r < KERNEL; r++) begin
         for (int c = 0; c < KERNEL; c++) begin
            win_flat[DATA_W*(r*KERNEL+c) +: DATA_W] = win[r][c];
         end
      end
   end

   assign bus.window_out = win_flat;
   assign bus.valid_out  = valid_q;
   assign bus.frame_done = frame_done_q;
endmodule
